// File: rtl/pipeline_vr.sv
// Three-stage flow-controlled pipeline computing F = ((A + B) + (C - D)) * D modulo 2^N,
// with a flag raised whenever the full product does not fit in N bits.
module pipeline_vr #(
   parameter int N = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [N-1:0] C,
   input  logic [N-1:0] D,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] F,
   output logic         ovf
);

   function automatic logic [2*N-1:0] mul_full(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] wa;
      logic [2*N-1:0] wb;
      wa = {{N{1'b0}}, a};
      wb = {{N{1'b0}}, b};
      return wa * wb;
   endfunction

   function automatic logic ovf_of(input logic [2*N-1:0] p);
      return |p[2*N-1:N];
   endfunction

   logic         vld_p1_q, vld_p2_q, vld_p3_q;
   logic [N-1:0] x1_p1_q, x2_p1_q, d_p1_q;
   logic [N-1:0] x3_p2_q, d_p2_q;
   logic [N-1:0] f_p3_q;
   logic         ovf_p3_q;

   logic [N-1:0]   x1_d, x2_d, x3_d;
   logic [2*N-1:0] prod_d;
   logic           r1, r2, r3;

   // Bubbles collapse: a stage may load whenever it is empty or its successor moves.
   always_comb begin
      r3       = !vld_p3_q || out_ready;
      r2       = !vld_p2_q || r3;
      r1       = !vld_p1_q || r2;
      in_ready = r1 && !rst;
      x1_d     = A + B;
      x2_d     = C - D;
      x3_d     = x1_p1_q + x2_p1_q;
      prod_d   = mul_full(x3_p2_q, d_p2_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         x1_p1_q  <= '0;
         x2_p1_q  <= '0;
         d_p1_q   <= '0;
         x3_p2_q  <= '0;
         d_p2_q   <= '0;
         f_p3_q   <= '0;
         ovf_p3_q <= 1'b0;
      end else begin
         // stage 1: operand sum and difference
         if (r1) begin
            vld_p1_q <= in_valid;
            if (in_valid) begin
               x1_p1_q <= x1_d;
               x2_p1_q <= x2_d;
               d_p1_q  <= D;
            end
         end
         // stage 2: combine, carry D along
         if (r2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
               x3_p2_q <= x3_d;
               d_p2_q  <= d_p1_q;
            end
         end
         // stage 3: multiply, keep low half, flag a non-zero high half
         if (r3) begin
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
               f_p3_q   <= prod_d[N-1:0];
               ovf_p3_q <= ovf_of(prod_d);
            end
         end
      end
   end

   assign out_valid = vld_p3_q;
   assign F         = f_p3_q;
   assign ovf       = ovf_p3_q;

endmodule

// File: tb/tb_pipeline_vr.sv
// Directed bench for pipeline_vr at N=10: reset, streaming, overflow, wrap,
// backpressure and mid-flight reset, each with hand-computed results.
module tb_pipeline_vr;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] a, b, c, d;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] f;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   // Operand sets and their hand-computed results.
   logic [9:0] va [5] = '{10'd10, 10'd5,  10'd1, 10'd50,  10'd0};
   logic [9:0] vb [5] = '{10'd20, 10'd10, 10'd2, 10'd50,  10'd0};
   logic [9:0] vc [5] = '{10'd30, 10'd20, 10'd3, 10'd100, 10'd0};
   logic [9:0] vd [5] = '{10'd40, 10'd15, 10'd4, 10'd20,  10'd1};
   logic [9:0] ef [5] = '{10'd800, 10'd300, 10'd8, 10'd528, 10'd1023};
   logic       eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   pipeline_vr #(.N(10)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .C(c), .D(d),
      .out_valid(out_valid), .out_ready(out_ready),
      .F(f), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k);
      in_valid = 1'b1;
      a = va[k]; b = vb[k]; c = vc[k]; d = vd[k];
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a = 10'd0; b = 10'd0; c = 10'd0; d = 10'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b1; drive(3);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid cyc%0d got %b want 0", i, out_valid); end
         checks++; if (f !== 10'd0) begin errors++; $display("FAIL rst_F cyc%0d got %0d want 0", i, f); end
         checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf cyc%0d got %b want 0", i, ovf); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready cyc%0d got %b want 0", i, in_ready); end
      end
      idle();
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(k);
         tick();
         if (k < 2) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency cyc%0d out_valid got %b want 0", k, out_valid); end
         end
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat%0d got %b want 1", k, out_valid); end
         checks++; if (f !== ef[k]) begin errors++; $display("FAIL stream_F beat%0d got %0d want %0d", k, f, ef[k]); end
         checks++; if (ovf !== eo[k]) begin errors++; $display("FAIL stream_ovf beat%0d got %b want %b", k, ovf, eo[k]); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain out_valid got %b want 0", out_valid); end
   endtask

   task automatic single_beat(input int k, input string name);
      out_ready = 1'b1;
      drive(k);
      tick();
      idle();
      tick();
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", name, out_valid); end
      checks++; if (f !== ef[k]) begin errors++; $display("FAIL %s_F got %0d want %0d", name, f, ef[k]); end
      checks++; if (ovf !== eo[k]) begin errors++; $display("FAIL %s_ovf got %b want %b", name, ovf, eo[k]); end
      tick();
   endtask

   task automatic test_overflow();
      single_beat(3, "overflow");
   endtask

   task automatic test_wrap();
      single_beat(4, "wrap");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(k);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept beat%0d in_ready got %b want 1", k, in_ready); end
         tick();
      end
      drive(3);
      for (int i = 0; i < 3; i++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready cyc%0d got %b want 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", i, out_valid); end
         checks++; if (f !== ef[0] || ovf !== eo[0]) begin errors++; $display("FAIL bp_hold_F cyc%0d got %0d/%b want %0d/%b", i, f, ovf, ef[0], eo[0]); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
      checks++; if (f !== ef[0]) begin errors++; $display("FAIL bp_release_F got %0d want %0d", f, ef[0]); end
      tick();
      drive(4);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_push_pop_in_ready got %b want 1", in_ready); end
      for (int k = 1; k < 5; k++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid beat%0d got %b want 1", k, out_valid); end
         checks++; if (f !== ef[k]) begin errors++; $display("FAIL bp_drain_F beat%0d got %0d want %0d", k, f, ef[k]); end
         checks++; if (ovf !== eo[k]) begin errors++; $display("FAIL bp_drain_ovf beat%0d got %b want %b", k, ovf, eo[k]); end
         tick();
         idle();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_midflight_reset();
      out_ready = 1'b1;
      drive(0);
      tick();
      drive(1);
      tick();
      idle();
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_discard cyc%0d out_valid got %b want 0", i, out_valid); end
         tick();
      end
      drive(3);
      tick();
      idle();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_early out_valid got %b want 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_after_valid got %b want 1", out_valid); end
      checks++; if (f !== ef[3] || ovf !== eo[3]) begin errors++; $display("FAIL mid_rst_after_F got %0d/%b want %0d/%b", f, ovf, ef[3], eo[3]); end
      tick();
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b1;
      idle();
      test_reset();
      test_streaming();
      test_overflow();
      test_wrap();
      test_backpressure();
      test_midflight_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
